mdio_phy_slave_mp: RTL and testbench
====================================

Name: mdio_phy_slave_mp

Overview:
- Serial MDIO (Clause 22) management slave for a multi-port PHY.
- Decodes frames bit by bit from the MDIO line, which is sampled on MDC.
- Claims a contiguous range of NUM_PORTS PHY addresses.
- Issues register-file write strobes and read requests, and drives read data back onto MDIO during the read data phase.
- Sits between the MDIO pad (tristate control exported) and the per-port register banks.

Parameters:
- PHY_BASE, 5'd4, first PHY address claimed. PHY_BASE+NUM_PORTS must be <= 32; otherwise elaboration fails.
- NUM_PORTS, 4, number of ports/PHY addresses claimed. Range 1..8.
- PRE_LEN, 32, consecutive 1s required before ST. 0 = preamble suppression: any 0 seen in PRE starts a frame.

Ports:
- MDC  in  1  management clock; all logic is on posedge.
- RESET  in  1  reset, synchronous, active-low.
- MDIO_I  in  1  sampled MDIO line.
- MDIO_O  out  1  value this block drives onto MDIO.
- MDIO_OE  out  1  1 = this block drives MDIO.
- RD_DATA  in  16  register read data; must be valid 1 cycle after RD_STB.
- PORT  out  3  port index = PHYAD-PHY_BASE; valid with RD_STB/WR_STB.
- ADDR  out  5  register address; valid with RD_STB/WR_STB.
- WR_DATA  out  16  write data; valid with WR_STB.
- WR_STB  out  1  one-cycle write strobe.
- RD_STB  out  1  one-cycle read request.
- MDIO_DONE  out  1  one-cycle pulse at the end of a claimed frame.
- ERR  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset (RESET=0 at a posedge): state=PRE, preamble count=0, all outputs 0. This applies mid-frame as well; MDIO_OE drops at that same edge.
- States: PRE, ST, OP, PHYAD, REGAD, TA, DATA. Bit counter is 5 bits. All fields are MSB first.
- PRE:
  - Each 1 increments the count, saturating at PRE_LEN.
  - A 0 with count>=PRE_LEN → ST. This 0 is the first ST bit.
  - A 0 with count<PRE_LEN → count=0, stay in PRE.
- ST:
  - Bit=1 → OP.
  - Bit=0 → ERR pulse, → PRE with count=0.
- OP:
  - 2 bits. 10=read, 01=write.
  - 00 or 11 → ERR pulse after the 2nd bit, → PRE.
- PHYAD:
  - 5 bits.
  - match = (PHYAD>=PHY_BASE) && (PHYAD<PHY_BASE+NUM_PORTS).
- REGAD:
  - 5 bits, then → TA.
  - Read with match: RD_STB=1 in the cycle after the edge that samples the last REGAD bit. PORT and ADDR are valid in that cycle.
- TA, read with match:
  - TA cycle 1: MDIO_OE=0. RD_DATA is latched at the end of this cycle (1 cycle after RD_STB).
  - TA cycle 2: MDIO_OE=1, MDIO_O=0.
- TA, write:
  - Sampled TA must be 10.
  - Otherwise: ERR pulse (only if match), → PRE, no WR_STB.
- DATA, write:
  - 16 bits shifted in.
  - With match: after the edge sampling D0, WR_STB=1 and MDIO_DONE=1 for exactly 1 cycle. WR_DATA, PORT and ADDR are held until the next strobe.
- DATA, read with match:
  - MDIO_OE=1. MDIO_O presents the latched data bit 15..0, one bit per cycle.
  - After D0's cycle: MDIO_OE=0 and a MDIO_DONE pulse.
- Non-matching PHYAD:
  - The FSM still walks the frame to its end, so it cannot false-sync on data.
  - No RD_STB, WR_STB, MDIO_OE or MDIO_DONE.
- End of every frame: → PRE with count=0. Preamble counting restarts at the first cycle after D0.
- MDIO_OE is never 1 outside TA cycle 2 and DATA of a matched read.

Optional Feature:
- Macro: MDIO_BCAST_EN
- Defined:
  - A write to PHYAD 0 (when 0 is outside the claimed range) is a broadcast.
  - A sequencer issues NUM_PORTS consecutive WR_STB pulses, with PORT=0..NUM_PORTS-1, the same ADDR/WR_DATA, and one port per cycle.
  - It starts in the cycle where a normal WR_STB would occur. MDIO_DONE pulses with the last strobe.
  - The sequencer runs independently of the frame FSM. A following frame cannot reach a strobe within 8 cycles.
  - Reads to PHYAD 0 are ignored.
- Undefined: PHYAD 0 is handled like any other address.

Test Plan:
- Preamble 32×1, write PHYAD=5, REGAD=0x0A, TA=10, data 0xBEEF → one WR_STB, PORT=1, ADDR=0x0A, WR_DATA=0xBEEF, MDIO_DONE same cycle; ERR=0.
- Read PHYAD=7, REGAD=0x03, RD_DATA=0xA55A → RD_STB with PORT=3, ADDR=3; MDIO_OE 0 in TA1, then 1 for 17 cycles; MDIO_O = 0 followed by 1010010101011010; MDIO_DONE after last bit.
- Write PHYAD=9 (out of range) with full frame → no strobes, MDIO_OE never 1; an immediately following valid write to PHYAD=4 after 32×1 is accepted.
- Preamble of 31×1 then ST → ignored; OP=11 after valid preamble → ERR pulse, no strobe; write with TA=11 to PHYAD=4 → ERR, no WR_STB.
- RESET=0 during DATA of a read → MDIO_OE=0 at that edge, all outputs 0; after release, 32×1 plus a valid write completes normally.
- MDIO_BCAST_EN: write PHYAD=0, REGAD=0x01, 0x1234 → 4 WR_STB pulses on consecutive cycles with PORT 0,1,2,3, WR_DATA=0x1234; MDIO_DONE with the 4th.

Source files
------------

// File: rtl/mdio_phy_slave_mp_if.sv
// rtl/mdio_phy_slave_mp_if.sv - MDIO pad and register-bank signals of mdio_phy_slave_mp
interface mdio_phy_slave_mp_if;
    logic        MDIO_I;
    logic        MDIO_O;
    logic        MDIO_OE;
    logic [15:0] RD_DATA;
    logic [2:0]  PORT;
    logic [4:0]  ADDR;
    logic [15:0] WR_DATA;
    logic        WR_STB;
    logic        RD_STB;
    logic        MDIO_DONE;
    logic        ERR;

    modport slave (
        input  MDIO_I, RD_DATA,
        output MDIO_O, MDIO_OE, PORT, ADDR, WR_DATA, WR_STB, RD_STB, MDIO_DONE, ERR
    );

    modport master (
        output MDIO_I, RD_DATA,
        input  MDIO_O, MDIO_OE, PORT, ADDR, WR_DATA, WR_STB, RD_STB, MDIO_DONE, ERR
    );
endinterface

// File: rtl/mdio_phy_slave_mp.sv
// rtl/mdio_phy_slave_mp.sv - Clause 22 MDIO slave claiming NUM_PORTS consecutive PHY addresses
// Define MDIO_BCAST_EN to turn writes to PHYAD 0 into a write to every port.
module mdio_phy_slave_mp #(
    parameter logic [4:0] PHY_BASE  = 5'd4,
    parameter int         NUM_PORTS = 4,
    parameter int         PRE_LEN   = 32
) (
    input  logic               MDC,
    input  logic               RESET,
    mdio_phy_slave_mp_if.slave bus
);
    localparam int             PCW     = $clog2(PRE_LEN + 2);
    localparam logic [PCW-1:0] PRE_MAX = PCW'(PRE_LEN);
    localparam int             ADDR_LO = int'(PHY_BASE);
    localparam int             ADDR_HI = ADDR_LO + NUM_PORTS;

    if (ADDR_HI > 32) begin : g_range_chk
        $error("mdio_phy_slave_mp: PHY_BASE + NUM_PORTS exceeds 32");
    end
    if ((NUM_PORTS < 1) || (NUM_PORTS > 8)) begin : g_ports_chk
        $error("mdio_phy_slave_mp: NUM_PORTS must be 1..8");
    end

    typedef enum logic [2:0] {
        S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     bit_cnt_q, bit_cnt_d;
    logic [PCW-1:0] pre_cnt_q, pre_cnt_d;
    logic [14:0]    sr_q, sr_d;
    logic [15:0]    rd_sr_q, rd_sr_d;
    logic           is_read_q, is_read_d;
    logic           match_q, match_d;
    logic [2:0]     fport_q, fport_d;
    logic [4:0]     regad_q, regad_d;
    logic           mdio_o_q, mdio_o_d;
    logic           mdio_oe_q, mdio_oe_d;
    logic [2:0]     port_q, port_d;
    logic [4:0]     addr_q, addr_d;
    logic [15:0]    wr_data_q, wr_data_d;
    logic           wr_stb_q, wr_stb_d;
    logic           rd_stb_q, rd_stb_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic [4:0]     field5;
    logic [1:0]     field2;
    logic           drive_rd;
    logic           wr_claim;

`ifdef MDIO_BCAST_EN
    localparam logic [2:0] LAST_PORT = 3'(NUM_PORTS - 1);
    logic       bcast_q, bcast_d;
    logic       seq_act_q, seq_act_d;
    logic [2:0] seq_port_q, seq_port_d;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 5'd1;
        pre_cnt_d = pre_cnt_q;
        sr_d      = {sr_q[13:0], bus.MDIO_I};
        rd_sr_d   = rd_sr_q;
        is_read_d = is_read_q;
        match_d   = match_q;
        fport_d   = fport_q;
        regad_d   = regad_q;
        mdio_o_d  = 1'b0;
        mdio_oe_d = 1'b0;
        port_d    = port_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_stb_d  = 1'b0;
        rd_stb_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        field5    = {sr_q[3:0], bus.MDIO_I};
        field2    = {sr_q[0], bus.MDIO_I};
        drive_rd  = is_read_q && match_q;
        wr_claim  = match_q;
`ifdef MDIO_BCAST_EN
        bcast_d    = bcast_q;
        seq_act_d  = seq_act_q;
        seq_port_d = seq_port_q;
        wr_claim   = match_q || bcast_q;
`endif

        case (state_q)
            S_PRE: begin
                bit_cnt_d = 5'd0;
                if (bus.MDIO_I) begin
                    if (pre_cnt_q < PRE_MAX) pre_cnt_d = pre_cnt_q + 1'b1;
                end else if (pre_cnt_q >= PRE_MAX) begin
                    state_d   = S_ST;
                    pre_cnt_d = '0;
                end else begin
                    pre_cnt_d = '0;
                end
            end
            S_ST: begin
                bit_cnt_d = 5'd0;
                if (bus.MDIO_I) begin
                    state_d = S_OP;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_PRE;
                end
            end
            S_OP: begin
                if (bit_cnt_q[0]) begin
                    bit_cnt_d = 5'd0;
                    is_read_d = (field2 == 2'b10);
                    if ((field2 == 2'b10) || (field2 == 2'b01)) begin
                        state_d = S_PHYAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_PRE;
                    end
                end
            end
            S_PHYAD: begin
                if (bit_cnt_q == 5'd4) begin
                    bit_cnt_d = 5'd0;
                    state_d   = S_REGAD;
                    match_d   = (int'(field5) >= ADDR_LO) && (int'(field5) < ADDR_HI);
                    fport_d   = 3'(field5 - PHY_BASE);
`ifdef MDIO_BCAST_EN
                    bcast_d   = !is_read_q && (field5 == 5'd0) && (PHY_BASE != 5'd0);
`endif
                end
            end
            S_REGAD: begin
                if (bit_cnt_q == 5'd4) begin
                    bit_cnt_d = 5'd0;
                    state_d   = S_TA;
                    regad_d   = field5;
                    if (drive_rd) begin
                        rd_stb_d = 1'b1;
                        port_d   = fport_q;
                        addr_d   = field5;
                    end
                end
            end
            S_TA: begin
                // Read data is captured one cycle after RD_STB, then we drive TA's 0.
                if (!bit_cnt_q[0]) begin
                    if (drive_rd) begin
                        rd_sr_d   = bus.RD_DATA;
                        mdio_oe_d = 1'b1;
                    end
                end else begin
                    bit_cnt_d = 5'd0;
                    state_d   = S_DATA;
                    if (drive_rd) begin
                        mdio_oe_d = 1'b1;
                        mdio_o_d  = rd_sr_q[15];
                        rd_sr_d   = {rd_sr_q[14:0], 1'b0};
                    end else if (!is_read_q && (field2 != 2'b10)) begin
                        err_d   = wr_claim;
                        state_d = S_PRE;
                    end
                end
            end
            S_DATA: begin
                if (bit_cnt_q != 5'd15) begin
                    if (drive_rd) begin
                        mdio_oe_d = 1'b1;
                        mdio_o_d  = rd_sr_q[15];
                        rd_sr_d   = {rd_sr_q[14:0], 1'b0};
                    end
                end else begin
                    bit_cnt_d = 5'd0;
                    state_d   = S_PRE;
                    if (drive_rd) begin
                        done_d = 1'b1;
                    end else if (!is_read_q && match_q) begin
                        wr_stb_d  = 1'b1;
                        done_d    = 1'b1;
                        port_d    = fport_q;
                        addr_d    = regad_q;
                        wr_data_d = {sr_q, bus.MDIO_I};
                    end
`ifdef MDIO_BCAST_EN
                    if (bcast_q) begin
                        wr_stb_d   = 1'b1;
                        done_d     = (NUM_PORTS == 1);
                        port_d     = 3'd0;
                        addr_d     = regad_q;
                        wr_data_d  = {sr_q, bus.MDIO_I};
                        seq_act_d  = (NUM_PORTS > 1);
                        seq_port_d = 3'd1;
                    end
`endif
                end
            end
            default: begin
                state_d = S_PRE;
            end
        endcase

`ifdef MDIO_BCAST_EN
        // Remaining broadcast strobes; ADDR/WR_DATA stay as loaded by the first one.
        if (seq_act_q) begin
            wr_stb_d   = 1'b1;
            port_d     = seq_port_q;
            done_d     = (seq_port_q == LAST_PORT);
            seq_act_d  = (seq_port_q != LAST_PORT);
            seq_port_d = seq_port_q + 3'd1;
        end
`endif
    end

    always_ff @(posedge MDC) begin
        if (!RESET) begin
            state_q   <= S_PRE;
            bit_cnt_q <= '0;
            pre_cnt_q <= '0;
            sr_q      <= '0;
            rd_sr_q   <= '0;
            is_read_q <= 1'b0;
            match_q   <= 1'b0;
            fport_q   <= '0;
            regad_q   <= '0;
            mdio_o_q  <= 1'b0;
            mdio_oe_q <= 1'b0;
            port_q    <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_stb_q  <= 1'b0;
            rd_stb_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef MDIO_BCAST_EN
            bcast_q    <= 1'b0;
            seq_act_q  <= 1'b0;
            seq_port_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            pre_cnt_q <= pre_cnt_d;
            sr_q      <= sr_d;
            rd_sr_q   <= rd_sr_d;
            is_read_q <= is_read_d;
            match_q   <= match_d;
            fport_q   <= fport_d;
            regad_q   <= regad_d;
            mdio_o_q  <= mdio_o_d;
            mdio_oe_q <= mdio_oe_d;
            port_q    <= port_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_stb_q  <= wr_stb_d;
            rd_stb_q  <= rd_stb_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef MDIO_BCAST_EN
            bcast_q    <= bcast_d;
            seq_act_q  <= seq_act_d;
            seq_port_q <= seq_port_d;
`endif
        end
    end

    assign bus.MDIO_O    = mdio_o_q;
    assign bus.MDIO_OE   = mdio_oe_q;
    assign bus.PORT      = port_q;
    assign bus.ADDR      = addr_q;
    assign bus.WR_DATA   = wr_data_q;
    assign bus.WR_STB    = wr_stb_q;
    assign bus.RD_STB    = rd_stb_q;
    assign bus.MDIO_DONE = done_q;
    assign bus.ERR       = err_q;
endmodule

// File: tb/tb_mdio_phy_slave_mp.sv
// tb/tb_mdio_phy_slave_mp.sv - randomized self-checking bench for mdio_phy_slave_mp
// Frames are described field by field; expected per-cycle outputs come from frame offsets.
module tb_mdio_phy_slave_mp;
    localparam logic [4:0] BASE = 5'd4;
    localparam int         NP   = 4;
    localparam int         PL   = 32;
    localparam int         MAXC = 8192;

    logic mdc    = 1'b0;
    logic resetn = 1'b0;

    mdio_phy_slave_mp_if bus ();

    mdio_phy_slave_mp #(
        .PHY_BASE (BASE),
        .NUM_PORTS(NP),
        .PRE_LEN  (PL)
    ) dut (
        .MDC  (mdc),
        .RESET(resetn),
        .bus  (bus)
    );

    always #5 mdc = ~mdc;

    logic [15:0] bank [256];
    assign bus.RD_DATA = bank[{bus.PORT, bus.ADDR}];

    // Stream of line bits and expected outputs for the cycle after each bit's sampling edge.
    bit          s_bit   [MAXC];
    bit          s_rst   [MAXC];
    logic [5:0]  e_vec   [MAXC];   // {oe, o, wr_stb, rd_stb, done, err}
    bit          e_bus   [MAXC];
    bit          e_wr    [MAXC];
    bit          e_zero  [MAXC];
    logic [2:0]  e_port  [MAXC];
    logic [4:0]  e_addr  [MAXC];
    logic [15:0] e_wdata [MAXC];
    int          len;
    int          n_cmp;
    int          n_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit b);
        s_bit[len] = b;
        s_rst[len] = 1'b0;
        len++;
    endtask

    task automatic expect_strobe(input int c, input logic [2:0] port, input logic [4:0] addr,
                                 input bit is_wr, input logic [15:0] wdata);
        e_bus[c]  = 1'b1;
        e_port[c] = port;
        e_addr[c] = addr;
        if (is_wr) begin
            e_wr[c]    = 1'b1;
            e_wdata[c] = wdata;
        end
    endtask

    task automatic add_frame(input int npre, input bit [1:0] st, input bit [1:0] op,
                             input bit [4:0] phyad, input bit [4:0] regad, input bit [1:0] ta,
                             input bit [15:0] data, input int rst_off);
        int          f0;
        int          p;
        bit          acc;
        bit          rd;
        bit          match;
        bit          bc;
        logic [2:0]  port;
        logic [15:0] d;
        f0    = len;
        p     = len + npre;
        acc   = (npre >= PL);
        rd    = (op == 2'b10);
        match = (phyad >= BASE) && (int'(phyad) < int'(BASE) + NP);
        port  = 3'(phyad - BASE);
        bc    = 1'b0;
`ifdef MDIO_BCAST_EN
        bc    = !rd && (phyad == 5'd0) && (BASE != 5'd0);
`endif
        for (int i = 0; i < npre; i++) push(1'b1);
        push(st[1]);
        push(st[0]);
        if (acc && st != 2'b01) begin
            e_vec[p+1][0] = 1'b1;
            return;
        end
        push(op[1]);
        push(op[0]);
        if (acc && !(op == 2'b10 || op == 2'b01)) begin
            e_vec[p+3][0] = 1'b1;
            return;
        end
        for (int i = 4; i >= 0; i--) push(phyad[i]);
        for (int i = 4; i >= 0; i--) push(regad[i]);
        if (rd) begin
            for (int i = 0; i < 18; i++) push(1'b1);
            if (acc && match) begin
                d = bank[{port, regad}];
                e_vec[p+13][2] = 1'b1;
                expect_strobe(p + 13, port, regad, 1'b0, 16'h0);
                e_vec[p+14] = 6'b100000;
                for (int j = 0; j < 16; j++) e_vec[p+15+j] = {1'b1, d[15-j], 4'b0000};
                e_vec[p+31][1] = 1'b1;
            end
        end else begin
            push(ta[1]);
            push(ta[0]);
            if (acc && ta != 2'b10) begin
                if (match || bc) e_vec[p+15][0] = 1'b1;
                return;
            end
            for (int i = 15; i >= 0; i--) push(data[i]);
            if (acc && match) begin
                e_vec[p+31] = 6'b001010;
                expect_strobe(p + 31, port, regad, 1'b1, data);
            end
            if (acc && bc) begin
                for (int i = 0; i < NP; i++) begin
                    e_vec[p+31+i] = {2'b00, 1'b1, 1'b0, (i == NP - 1), 1'b0};
                    expect_strobe(p + 31 + i, 3'(i), regad, 1'b1, data);
                end
            end
        end
        if (rst_off >= 0) begin
            s_rst[f0+rst_off]  = 1'b1;
            e_zero[f0+rst_off] = 1'b1;
            for (int k = f0 + rst_off; k < len; k++) begin
                e_vec[k] = '0;
                e_bus[k] = 1'b0;
                e_wr[k]  = 1'b0;
            end
        end
    endtask

    task automatic check_cycle(input int k);
        logic [5:0] obs;
        obs = {bus.MDIO_OE, bus.MDIO_OE & bus.MDIO_O, bus.WR_STB, bus.RD_STB, bus.MDIO_DONE, bus.ERR};
        chk($sformatf("flags@%0d", k), 32'(obs), 32'(e_vec[k]));
        if (e_bus[k])
            chk($sformatf("port_addr@%0d", k), 32'({bus.PORT, bus.ADDR}), 32'({e_port[k], e_addr[k]}));
        if (e_wr[k])
            chk($sformatf("wr_data@%0d", k), 32'(bus.WR_DATA), 32'(e_wdata[k]));
        if (e_zero[k])
            chk($sformatf("reset_regs@%0d", k), 32'({bus.PORT, bus.ADDR, bus.WR_DATA, bus.MDIO_O}), 32'd0);
    endtask

    initial begin
        int          npre;
        int          r;
        bit          prev_ign;
        bit [1:0]    st;
        bit [1:0]    op;
        bit [1:0]    ta;
        bit [4:0]    phyad;
        bit [15:0]   data;
        n_cmp      = 0;
        n_bad      = 0;
        len        = 0;
        bus.MDIO_I = 1'b1;
        for (int i = 0; i < 256; i++) bank[i] = 16'($urandom);
        bank[{3'd3, 5'd3}] = 16'hA55A;
        for (int k = 0; k < MAXC; k++) begin
            e_vec[k]   = '0;
            e_bus[k]   = 1'b0;
            e_wr[k]    = 1'b0;
            e_zero[k]  = 1'b0;
            e_port[k]  = '0;
            e_addr[k]  = '0;
            e_wdata[k] = '0;
        end

        // Directed frames
        add_frame(32, 2'b01, 2'b01, 5'd5, 5'h0A, 2'b10, 16'hBEEF, -1);
        add_frame(32, 2'b01, 2'b10, 5'd7, 5'h03, 2'b10, 16'h0000, -1);
        add_frame(32, 2'b01, 2'b01, 5'd9, 5'h11, 2'b10, 16'h1357, -1);
        add_frame(32, 2'b01, 2'b01, 5'd4, 5'h02, 2'b10, 16'hC0DE, -1);
        add_frame(31, 2'b01, 2'b01, 5'd4, 5'h05, 2'b10, 16'hFFFF, -1);
        add_frame(32, 2'b01, 2'b11, 5'd4, 5'h05, 2'b10, 16'h0000, -1);
        add_frame(32, 2'b01, 2'b01, 5'd4, 5'h06, 2'b11, 16'h0000, -1);
        add_frame(32, 2'b01, 2'b10, 5'd6, 5'h07, 2'b10, 16'h0000, 52);
        add_frame(32, 2'b01, 2'b01, 5'd6, 5'h08, 2'b10, 16'h5AA5, -1);
        add_frame(32, 2'b01, 2'b01, 5'd0, 5'h01, 2'b10, 16'h1234, -1);
        add_frame(32, 2'b01, 2'b01, 5'd7, 5'h1F, 2'b10, 16'h8001, -1);

        // Random frames
        prev_ign = 1'b0;
        for (int f = 0; f < 45; f++) begin
            r     = $urandom_range(0, 99);
            npre  = 32 + $urandom_range(0, 2);
            st    = 2'b01;
            op    = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
            ta    = 2'b10;
            phyad = (r < 70) ? BASE + 5'($urandom_range(0, NP - 1)) : 5'($urandom_range(0, 31));
            data  = 16'($urandom);
            if (!prev_ign && (r % 10 == 0))  npre = 31;
            else if (r % 10 == 1)            st = 2'b00;
            else if (r % 10 == 2)            op = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
            else if (r % 10 == 3)            ta = 2'($urandom_range(0, 3));
            add_frame(npre, st, op, phyad, 5'($urandom), ta, data, -1);
            prev_ign = (npre < PL);
        end
        for (int i = 0; i < 40; i++) push(1'b1);

        // Reset state
        repeat (3) @(negedge mdc);
        chk("reset_flags", 32'({bus.MDIO_OE, bus.MDIO_O, bus.WR_STB, bus.RD_STB, bus.MDIO_DONE, bus.ERR}), 32'd0);
        chk("reset_regs", 32'({bus.PORT, bus.ADDR, bus.WR_DATA}), 32'd0);

        for (int k = 0; k < len; k++) begin
            @(negedge mdc);
            if (k > 0) check_cycle(k - 1);
            bus.MDIO_I = s_bit[k];
            resetn     = !s_rst[k];
        end
        @(negedge mdc);
        check_cycle(len - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
